// File: rtl/div_sequencer_pkg.sv
// Shared constants and FSM encoding for the execute-stage divide sequencer.
package div_sequencer_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;
  localparam int DIV_ITERS = 32;

  typedef enum logic [1:0] {
    DIV_IDLE  = 2'd0,
    DIV_RUN   = 2'd1,
    DIV_FIXUP = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_sequencer_if.sv
// Pipeline-to-divider bundle: issue/operand/MF inputs, HI/LO and status back.
interface div_sequencer_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             is_mf_hi;
  logic             is_mf_lo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, is_mf_hi, is_mf_lo,
    input  hi, lo, busy, stall, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, is_mf_hi, is_mf_lo,
    output hi, lo, busy, stall, div_by_zero
  );

endinterface

// File: rtl/div_sequencer_step.sv
// One restoring-division iteration on unsigned magnitudes: shift {rem,quo}
// left, subtract the divisor when it fits.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_abs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0]   rem_sh_s;
  logic [WIDTH+1:0] trial_s;

  // Trial subtract with an extra guard bit so the top bit is a clean borrow.
  always_comb begin
    rem_sh_s = {rem, quo[WIDTH-1]};
    trial_s  = {1'b0, rem_sh_s} - {2'b00, divisor_abs};
    if (trial_s[WIDTH+1] == 1'b0) begin
      rem_next = WIDTH'(trial_s);
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh_s[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage signed divide controller: 32-step restoring divide into HI/LO
// with pipeline stall while a dependent MF or second DIV waits for the result.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = DIV_CNT_W
) (
  input  logic          clock,
  input  logic          reset,
  div_sequencer_if.slave bus
);

  localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

  div_state_t       state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dsr_abs_r;
  logic             q_neg_r;
  logic             r_neg_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             dbz_r;
  logic [WIDTH-1:0] rem_nx_s;
  logic [WIDTH-1:0] quo_nx_s;
  logic             busy_s;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_r),
    .quo         (quo_r),
    .divisor_abs (dsr_abs_r),
    .rem_next    (rem_nx_s),
    .quo_next    (quo_nx_s)
  );

  // Sequencer FSM, datapath registers and HI/LO commit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= DIV_IDLE;
      cnt_r     <= {CNT_W{1'b0}};
      rem_r     <= ZERO_W;
      quo_r     <= ZERO_W;
      dsr_abs_r <= ZERO_W;
      q_neg_r   <= 1'b0;
      r_neg_r   <= 1'b0;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      dbz_r     <= 1'b0;
    end else begin
      case (state_r)
        DIV_IDLE: begin
          if (bus.start) begin
            if (bus.divisor == ZERO_W) begin
              lo_r  <= ONES_W;
              hi_r  <= bus.dividend;
              dbz_r <= 1'b1;
            end else begin
              // Magnitudes only; -2^(WIDTH-1) maps onto itself as an unsigned value.
              quo_r     <= bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
              dsr_abs_r <= bus.divisor[WIDTH-1] ? -bus.divisor : bus.divisor;
              rem_r     <= ZERO_W;
              cnt_r     <= {CNT_W{1'b0}};
              q_neg_r   <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              r_neg_r   <= bus.dividend[WIDTH-1];
              state_r   <= DIV_RUN;
            end
          end
        end
        DIV_RUN: begin
          rem_r <= rem_nx_s;
          quo_r <= quo_nx_s;
          cnt_r <= cnt_r + 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_r <= DIV_FIXUP;
          end
        end
        DIV_FIXUP: begin
          lo_r    <= q_neg_r ? -quo_r : quo_r;
          hi_r    <= r_neg_r ? -rem_r : rem_r;
          dbz_r   <= 1'b0;
          state_r <= DIV_IDLE;
        end
        default: begin
          state_r <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy_s          = (state_r != DIV_IDLE);
  assign bus.busy        = busy_s;
  // Combinational so a dependent instruction is held in the very cycle it arrives.
  assign bus.stall       = busy_s & (bus.is_mf_hi | bus.is_mf_lo | bus.start);
  assign bus.hi          = hi_r;
  assign bus.lo          = lo_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: cycle-level result/latency model plus
// directed literal checks.
module tb_div_sequencer;

  logic clock;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  div_sequencer_if #(.WIDTH(32)) bus ();

  div_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Architectural model: committed HI/LO/flag plus a pending result that
  // lands after a 33-cycle busy window.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  logic        m_dbz;
  int          m_cnt;

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = sa / sb;
    r  = sa - q * sb;
    return {r[31:0], q[31:0]};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_dbz <= 1'b0; m_cnt <= 0;
      p_hi <= 32'd0; p_lo <= 32'd0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_hi <= p_hi; m_lo <= p_lo; m_dbz <= 1'b0;
      end
    end else if (bus.start) begin
      if (bus.divisor == 32'd0) begin
        m_hi <= bus.dividend; m_lo <= 32'hFFFFFFFF; m_dbz <= 1'b1;
      end else begin
        p_hi  <= ref_div(bus.dividend, bus.divisor) >> 32;
        p_lo  <= ref_div(bus.dividend, bus.divisor) & 64'h00000000FFFFFFFF;
        m_cnt <= 33;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clock) begin
    chk("hi", bus.hi, m_hi);
    chk("lo", bus.lo, m_lo);
    chk("dbz", {31'd0, bus.div_by_zero}, {31'd0, m_dbz});
    chk("busy", {31'd0, bus.busy}, {31'd0, m_cnt != 0});
    chk("stall", {31'd0, bus.stall},
        {31'd0, (m_cnt != 0) && (bus.is_mf_hi || bus.is_mf_lo || bus.start)});
  end

  // Present a DIV held by the pipeline until not stalled; returns stalled cycles.
  task automatic do_div(input logic [31:0] a, input logic [31:0] b, output int n);
    logic s;
    int   g;
    n = 0; g = 0;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    do begin
      @(negedge clock); s = bus.stall;
      if (s) n++;
      @(posedge clock); #1; g++;
    end while (s && g < 200);
    if (g >= 200) chk("accept_timeout", 32'd1, 32'd0);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (m_cnt != 0 && g < 200) begin
      @(posedge clock); #1; g++;
    end
    if (g >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int n;
    logic [31:0] a, b;
    reset = 1'b1;
    bus.start = 1'b0; bus.dividend = 32'd0; bus.divisor = 32'd0;
    bus.is_mf_hi = 1'b0; bus.is_mf_lo = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    reset = 1'b0;

    // 100 / 7 with busy-window length
    do_div(32'd100, 32'd7, n);
    n = 0;
    repeat (40) begin
      @(negedge clock);
      if (bus.busy) n++;
    end
    @(posedge clock); #1;
    chk("t1_busy_cycles", n, 32'd33);
    chk("t1_lo", bus.lo, 32'd14);
    chk("t1_hi", bus.hi, 32'd2);
    chk("t1_dbz", {31'd0, bus.div_by_zero}, 32'd0);

    do_div(-32'd100, 32'd7, n); wait_idle();
    chk("t2_lo", bus.lo, 32'hFFFFFFF2);
    chk("t2_hi", bus.hi, 32'hFFFFFFFE);
    do_div(32'd100, -32'd7, n); wait_idle();
    chk("t2b_lo", bus.lo, 32'hFFFFFFF2);
    chk("t2b_hi", bus.hi, 32'd2);

    do_div(32'h80000000, 32'hFFFFFFFF, n); wait_idle();
    chk("t3_ovf_lo", bus.lo, 32'h80000000);
    chk("t3_ovf_hi", bus.hi, 32'd0);
    chk("t3_ovf_dbz", {31'd0, bus.div_by_zero}, 32'd0);
    do_div(32'd5, 32'd0, n);
    chk("t3_dz_lo", bus.lo, 32'hFFFFFFFF);
    chk("t3_dz_hi", bus.hi, 32'd5);
    chk("t3_dz_flag", {31'd0, bus.div_by_zero}, 32'd1);
    chk("t3_dz_busy", {31'd0, bus.busy}, 32'd0);

    // MFLO held behind a running divide
    do_div(32'd50, 32'd6, n);
    bus.is_mf_lo = 1'b1;
    n = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clock);
      if (!bus.stall) break;
      n++;
    end
    chk("t4_stall_cycles", n, 32'd33);
    chk("t4_release_lo", bus.lo, 32'd8);
    @(posedge clock); #1;
    bus.is_mf_lo = 1'b0;
    do_div(32'd50, 32'd6, n);
    do_div(32'd17, 32'd5, n);
    chk("t4_second_stall", n, 32'd33);
    wait_idle();
    chk("t4_second_lo", bus.lo, 32'd3);
    chk("t4_second_hi", bus.hi, 32'd2);

    // Reset in the middle of a run
    do_div(32'd100, 32'd7, n);
    bus.is_mf_lo = 1'b1;
    repeat (10) @(posedge clock);
    #1; reset = 1'b1;
    @(negedge clock);
    chk("t5_busy", {31'd0, bus.busy}, 32'd0);
    chk("t5_stall", {31'd0, bus.stall}, 32'd0);
    chk("t5_hi", bus.hi, 32'd0);
    chk("t5_lo", bus.lo, 32'd0);
    @(posedge clock); #1;
    reset = 1'b0; bus.is_mf_lo = 1'b0;
    do_div(32'd9, 32'd3, n); wait_idle();
    chk("t5_lo_after", bus.lo, 32'd3);
    chk("t5_hi_after", bus.hi, 32'd0);

    // Random signed pairs; operands scrambled while running
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if (i % 4 == 0) begin
        b = $urandom_range(1, 15);
        if (i % 8 == 0) b = -b;
      end else begin
        b = $urandom;
      end
      if (b == 32'd0) b = 32'd1;
      do_div(a, b, n);
      bus.dividend = $urandom; bus.divisor = $urandom;
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
